// File: rtl/switch_debouncer_if.sv
// Switch bus between the raw board switches, the debouncer and the
// downstream control logic.
//   i_sw     : raw asynchronous switch levels
//   o_sw     : debounced switch levels (bit 0 enable, bits 2:1 limit select,
//              bit 3 colour)
//   o_rise   : one-cycle strobe per bit on a debounced 0->1
//   o_fall   : one-cycle strobe per bit on a debounced 1->0
//   o_change : one-cycle strobe, OR of all rise/fall bits
// master : side that supplies the switches and consumes the result
// slave  : the debouncer
interface switch_debouncer_if #(
  parameter int NB_SW = 4
);
  logic [NB_SW-1:0] i_sw;
  logic [NB_SW-1:0] o_sw;
  logic [NB_SW-1:0] o_rise;
  logic [NB_SW-1:0] o_fall;
  logic             o_change;

  modport master (
    output i_sw,
    input  o_sw,
    input  o_rise,
    input  o_fall,
    input  o_change
  );

  modport slave (
    input  i_sw,
    output o_sw,
    output o_rise,
    output o_fall,
    output o_change
  );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit 2-flop synchroniser followed by a
// per-bit stability counter. A new level reaches o_sw only after it has
// been seen on the synchronised input for DEB_LIMIT consecutive cycles;
// any cycle back at the current debounced level restarts the window.
// Registered rise/fall/change strobes accompany every update.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high
//   sw_bus : switch bus (slave side), see switch_debouncer_if
// Legal configuration: 1 <= DEB_LIMIT <= 2**NB_DEB.
module switch_debouncer #(
  parameter int NB_SW     = 4,
  parameter int NB_DEB    = 20,
  parameter int DEB_LIMIT = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  switch_debouncer_if.slave  sw_bus
);

  localparam logic [NB_DEB-1:0] LIMIT_M1 = NB_DEB'(DEB_LIMIT - 1);

  logic [NB_SW-1:0]             meta;
  logic [NB_SW-1:0]             sync;
  logic [NB_SW-1:0][NB_DEB-1:0] cnt;
  logic [NB_SW-1:0][NB_DEB-1:0] cnt_next;
  logic [NB_SW-1:0]             sw_q;
  logic [NB_SW-1:0]             sw_next;
  logic [NB_SW-1:0]             rise_next;
  logic [NB_SW-1:0]             fall_next;
  logic [NB_SW-1:0]             rise_q;
  logic [NB_SW-1:0]             fall_q;
  logic                         change_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= sw_bus.i_sw;
      sync <= meta;
    end
  end

  always_comb begin
    cnt_next  = cnt;
    sw_next   = sw_q;
    rise_next = '0;
    fall_next = '0;
    for (int unsigned k = 0; k < NB_SW; k++) begin
      if (sync[k] == sw_q[k]) begin
        cnt_next[k] = '0;
      end else if (cnt[k] == LIMIT_M1) begin
        sw_next[k]   = sync[k];
        cnt_next[k]  = '0;
        rise_next[k] = sync[k];
        fall_next[k] = ~sync[k];
      end else begin
        cnt_next[k] = cnt[k] + NB_DEB'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      sw_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      sw_q     <= sw_next;
      rise_q   <= rise_next;
      fall_q   <= fall_next;
      change_q <= |(rise_next | fall_next);
    end
  end

  assign sw_bus.o_sw     = sw_q;
  assign sw_bus.o_rise   = rise_q;
  assign sw_bus.o_fall   = fall_q;
  assign sw_bus.o_change = change_q;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions raw board slide switches before they reach the LED shift-register stage, which consumes o_sw as its switch bus: enable on bit 0, limit select on bits 2:1, colour on bit 3.
- Per-bit 2-flop synchroniser, then a per-bit stability counter.
- A new level propagates only after it has been stable for DEB_LIMIT consecutive cycles.
- Also emits one-cycle rise/fall/change strobes for downstream control logic.

Parameters:
- NB_SW, 4, number of switch bits handled (independent lanes).
- NB_DEB, 20, width of each per-bit stability counter.
- DEB_LIMIT, 1000000, consecutive stable cycles required (10 ms at 100 MHz). Legal range 1 <= DEB_LIMIT <= 2**NB_DEB.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_sw  input  NB_SW  raw asynchronous switch levels.
- o_sw  output  NB_SW  debounced switch levels (registered).
- o_rise  output  NB_SW  one-cycle pulse per bit when o_sw[k] goes 0->1.
- o_fall  output  NB_SW  one-cycle pulse per bit when o_sw[k] goes 1->0.
- o_change  output  1  one-cycle pulse: OR of all o_rise and o_fall bits (registered, same cycle as them).

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset (asynchronous assert, released synchronously by the system):
  - sync stages = 0, all counters = 0.
  - o_sw = 0, o_rise = 0, o_fall = 0, o_change = 0.
- Synchroniser, per bit k:
  - meta[k] <= i_sw[k]; sync[k] <= meta[k].
  - No other logic reads i_sw or meta.
- Debounce, per bit k, evaluated every edge:
  - sync[k] == o_sw[k]: cnt[k] <= 0; no pulse.
  - sync[k] != o_sw[k] and cnt[k] == DEB_LIMIT-1: o_sw[k] <= sync[k]; cnt[k] <= 0; the matching rise/fall bit goes high for exactly this cycle.
  - Otherwise: cnt[k] <= cnt[k]+1 (NB_DEB-bit unsigned; cannot wrap while legal range holds).
- Latency: count the edge that first samples a new stable i_sw level into meta as edge 1. o_sw updates on edge DEB_LIMIT+2.
  - DEB_LIMIT=1 -> edge 3.
  - DEB_LIMIT=4 -> edge 6.
- Glitch rejection: any single cycle where sync[k] returns to o_sw[k] clears cnt[k]. The stability window restarts from zero.
- Strobes:
  - o_rise/o_fall/o_change are registered, never high two consecutive cycles for the same bit transition.
  - They are 0 in every cycle where no lane updated.
- Lanes are fully independent. Several bits may update on the same edge, giving multiple o_rise/o_fall bits together and a single o_change pulse.
- Opposite bounce after an update: a new transition requires a fresh DEB_LIMIT-cycle window. There is no hysteresis beyond that.
- Reset mid-count:
  - Counters and outputs clear immediately, with no strobe.
  - After release, a switch still held at 1 produces a rise pulse on edge DEB_LIMIT+2 after release.
- DEB_LIMIT outside the legal range is an illegal configuration. Behaviour is not defined; the bench does not test it.

Test Plan (DEB_LIMIT=4, NB_SW=4, NB_DEB=4):
- Reset: assert reset with i_sw=4'hF mid-run -> all outputs 0 immediately, asynchronously to clock. After release with i_sw held at 4'hF: o_sw=4'hF, o_rise=4'hF and o_change=1 on edge 6, all strobes 0 on edge 7.
- Clean press: i_sw 0->4'b0001 held -> o_sw[0]=1 on edge 6, o_rise=4'b0001 for one cycle, o_fall=0. Release -> o_sw[0]=0 on edge 6, o_fall=4'b0001 for one cycle.
- Bounce: i_sw[1] toggles 1,0,1,0,1 one cycle each, then holds at 1 -> no strobe during the toggling. o_sw[1]=1 exactly 6 edges after the final 0->1.
- Short pulse: i_sw[2]=1 for 3 cycles, then 0 -> o_sw, o_rise and o_change remain 0 throughout.
- Simultaneous: i_sw 4'b0101 -> 4'b1010 on one edge, held -> on edge 6 o_sw=4'b1010, o_rise=4'b1010, o_fall=4'b0101, single-cycle o_change=1.
- Downstream check: drive i_sw=4'b1001 into the debouncer feeding the shift-register stage -> its enable and colour select take effect only after the 6-edge latency, with no intermediate glitching of o_sw.
